trap_return_unit: RTL and testbench
===================================

TRAP_RETURN_UNIT -- requirements
Module: trap_return_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter RESET_MTVEC, default 32'h0000_0000, reset trap vector.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port instr_valid  input  1  decode-stage instruction valid.
REQ-006 SHALL have port ecall_type  input  1  decoded ECALL, qualified by instr_valid.
REQ-007 SHALL have port mret_type  input  1  decoded MRET, qualified by instr_valid.
REQ-008 SHALL have port pc  input  XLEN  PC of the decoded instruction.
REQ-009 SHALL have ports csr_we, csr_addr, csr_wdata  input  1/12/XLEN  CSR-instruction write port.
REQ-010 SHALL have port csr_rdata  output  XLEN  combinational read of csr_addr; 0 for unmapped addresses.
REQ-011 SHALL have port stall  output  1  holds upstream pipeline.
REQ-012 SHALL have ports redirect_valid, redirect_pc  output  1/XLEN  one-cycle PC redirect.
REQ-013 SHALL have port flush  output  1  kills younger instructions; equals redirect_valid.

Function
REQ-014 SHALL implement mstatus 0x300 (MIE bit3, MPIE bit7, MPP[12:11] read-only 2'b11, other bits read 0), mtvec 0x305, mepc 0x341, mcause 0x342.
REQ-015 SHALL force mtvec[1:0] and mepc[1:0] to 0 on every write.
REQ-016 SHALL implement FSM IDLE -> SAVE -> REDIRECT -> IDLE; no other states.
REQ-017 IDLE: instr_valid & (ecall_type | mret_type) SHALL latch event kind and pc, go to SAVE.
REQ-018 SAVE, ECALL: mepc<=latched pc, mcause<=11, MPIE<=MIE, MIE<=0.
REQ-019 SAVE, MRET: MIE<=MPIE, MPIE<=1; mepc/mcause unchanged.
REQ-020 REDIRECT: redirect_valid=flush=1 for exactly one cycle; redirect_pc=mtvec (ECALL) or mepc (MRET).
REQ-021 stall SHALL be 1 in SAVE and REDIRECT, 0 in IDLE; redirect asserted 2 cycles after event sample.
REQ-022 ecall_type and mret_type both high SHALL be treated as ECALL.
REQ-023 Events while not in IDLE SHALL be ignored.
REQ-024 csr_we in SAVE targeting a register updated by SAVE SHALL be dropped for that register; trap update wins.
REQ-025 csr_we in IDLE/REDIRECT SHALL take effect at the next edge; csr_rdata SHALL reflect pre-edge values.

Reset
REQ-026 reset SHALL immediately force IDLE, stall=0, redirect_valid=flush=0, redirect_pc=0.
REQ-027 reset SHALL set mtvec=RESET_MTVEC, mepc=0, mcause=0, MIE=0, MPIE=0.
REQ-028 reset mid-SAVE/REDIRECT SHALL abandon the event without any CSR update or redirect.

Configuration
REQ-029 Macro TRAP_EXT_INTERRUPT_EN SHALL, when defined, add input ext_irq (1 bit) and CSR mie 0x304 (MEIE bit11).
REQ-030 With it defined: ext_irq & MIE & MEIE in IDLE with no event SHALL trap like ECALL but mcause=32'h8000_000B, mepc=pc; ECALL/MRET take priority over ext_irq.
REQ-031 Without it: no ext_irq port, 0x304 reads 0, behaviour per REQ-014..028 only.

Verification
REQ-032 mtvec write 0x0000_0103, ECALL at pc 0x80 -> redirect_pc 0x100 two cycles later, mepc 0x80, mcause 11, MIE 0.
REQ-033 mstatus write 0x8 then ECALL then MRET -> after MRET MIE=1, MPIE=1, redirect_pc=0x80.
REQ-034 ecall_type and mret_type high together -> ECALL path, mcause 11; second ECALL during stall ignored.
REQ-035 csr_we to mepc 0x200 during SAVE of ECALL at pc 0x40 -> mepc reads 0x40.
REQ-036 reset asserted in SAVE -> stall low immediately, no redirect_valid, mepc remains 0.
REQ-037 With TRAP_EXT_INTERRUPT_EN: MIE=1, MEIE=1, ext_irq=1 at pc 0x24 -> mcause 0x8000_000B, mepc 0x24, redirect to mtvec.

Source files
------------

// File: rtl/trap_return_unit.sv
// trap_return_unit
//   Machine-mode trap entry (ECALL) and trap return (MRET) sequencer with the
//   small CSR file that backs it (mstatus, mtvec, mepc, mcause).
//   A qualified event in IDLE is latched, the CSR side effects are applied in
//   SAVE, and a one-cycle PC redirect/flush is issued from REDIRECT. The
//   pipeline is stalled for the whole SAVE/REDIRECT window.
//
// Optional feature (macro TRAP_EXT_INTERRUPT_EN):
//   Adds input ext_irq and the mie CSR (0x304, MEIE at bit 11). A pending,
//   enabled external interrupt in IDLE traps like ECALL with the interrupt
//   cause code. ECALL/MRET take priority over it.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   instr_valid           decode-stage instruction valid
//   ecall_type, mret_type decoded ECALL / MRET, qualified by instr_valid
//   pc                    PC of the decoded instruction
//   csr_we/addr/wdata     CSR-instruction write port
//   csr_rdata             combinational read of csr_addr (0 when unmapped)
//   stall                 holds the upstream pipeline
//   redirect_valid/pc     one-cycle PC redirect
//   flush                 kills younger instructions (same as redirect_valid)
//   ext_irq               external interrupt request (macro builds only)

module trap_return_unit #(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            instr_valid,
   input  logic            ecall_type,
   input  logic            mret_type,
   input  logic [XLEN-1:0] pc,
   input  logic            csr_we,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
`ifdef TRAP_EXT_INTERRUPT_EN
   input  logic            ext_irq,
`endif
   output logic [XLEN-1:0] csr_rdata,
   output logic            stall,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
`ifdef TRAP_EXT_INTERRUPT_EN
   localparam logic [11:0] ADDR_MIE     = 12'h304;
`endif

   localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);
   localparam logic [XLEN-1:0] CAUSE_IRQ   = {1'b1, (XLEN-1)'(11)};
   localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(3);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SAVE     = 2'd1,
      ST_REDIRECT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      EV_ECALL = 2'd0,
      EV_MRET  = 2'd1,
      EV_IRQ   = 2'd2
   } ev_kind_t;

   state_t          state_q, state_d;
   ev_kind_t        ev_kind_q, ev_kind_d;
   logic [XLEN-1:0] ev_pc_q, ev_pc_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;
   logic            mie_q, mie_d;       // mstatus.MIE
   logic            mpie_q, mpie_d;     // mstatus.MPIE
`ifdef TRAP_EXT_INTERRUPT_EN
   logic            meie_q, meie_d;     // mie.MEIE
`endif
   logic            stall_d;
   logic            redirect_valid_d;
   logic [XLEN-1:0] redirect_pc_d;
   logic            event_c;

   assign event_c = instr_valid & (ecall_type | mret_type);

   // Next-state, CSR update and output computation
   always_comb begin
      state_d          = state_q;
      ev_kind_d        = ev_kind_q;
      ev_pc_d          = ev_pc_q;
      mtvec_d          = mtvec_q;
      mepc_d           = mepc_q;
      mcause_d         = mcause_q;
      mie_d            = mie_q;
      mpie_d           = mpie_q;
`ifdef TRAP_EXT_INTERRUPT_EN
      meie_d           = meie_q;
`endif
      stall_d          = 1'b0;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = '0;

      // Software CSR writes; any SAVE update below overrides them
      if (csr_we) begin
         case (csr_addr)
            ADDR_MSTATUS: begin
               mie_d  = csr_wdata[3];
               mpie_d = csr_wdata[7];
            end
            ADDR_MTVEC:  mtvec_d  = csr_wdata & ALIGN_MASK;
            ADDR_MEPC:   mepc_d   = csr_wdata & ALIGN_MASK;
            ADDR_MCAUSE: mcause_d = csr_wdata;
`ifdef TRAP_EXT_INTERRUPT_EN
            ADDR_MIE:    meie_d   = csr_wdata[11];
`endif
            default: ;
         endcase
      end

      case (state_q)
         ST_IDLE: begin
            if (event_c) begin
               // ECALL wins when both decode flags are set
               ev_kind_d = ecall_type ? EV_ECALL : EV_MRET;
               ev_pc_d   = pc;
               state_d   = ST_SAVE;
            end
`ifdef TRAP_EXT_INTERRUPT_EN
            else if (ext_irq && mie_q && meie_q) begin
               ev_kind_d = EV_IRQ;
               ev_pc_d   = pc;
               state_d   = ST_SAVE;
            end
`endif
         end
         ST_SAVE: begin
            state_d = ST_REDIRECT;
            if (ev_kind_q == EV_MRET) begin
               mie_d  = mpie_q;
               mpie_d = 1'b1;
            end else begin
               mepc_d   = ev_pc_q & ALIGN_MASK;
               mcause_d = (ev_kind_q == EV_IRQ) ? CAUSE_IRQ : CAUSE_ECALL;
               mpie_d   = mie_q;
               mie_d    = 1'b0;
            end
         end
         ST_REDIRECT: state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase

      // Outputs are registered, so derive them from the upcoming state
      stall_d          = (state_d != ST_IDLE);
      redirect_valid_d = (state_d == ST_REDIRECT);
      if (state_d == ST_REDIRECT)
         redirect_pc_d = (ev_kind_q == EV_MRET) ? mepc_d : mtvec_d;
   end

   // State, CSR and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         ev_kind_q      <= EV_ECALL;
         ev_pc_q        <= '0;
         mtvec_q        <= RESET_MTVEC;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mie_q          <= 1'b0;
         mpie_q         <= 1'b0;
`ifdef TRAP_EXT_INTERRUPT_EN
         meie_q         <= 1'b0;
`endif
         stall          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         state_q        <= state_d;
         ev_kind_q      <= ev_kind_d;
         ev_pc_q        <= ev_pc_d;
         mtvec_q        <= mtvec_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         mie_q          <= mie_d;
         mpie_q         <= mpie_d;
`ifdef TRAP_EXT_INTERRUPT_EN
         meie_q         <= meie_d;
`endif
         stall          <= stall_d;
         redirect_valid <= redirect_valid_d;
         redirect_pc    <= redirect_pc_d;
      end
   end

   assign flush = redirect_valid;

   // Combinational CSR read of the pre-edge register values
   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         ADDR_MSTATUS: begin
            csr_rdata[3]     = mie_q;
            csr_rdata[7]     = mpie_q;
            csr_rdata[12:11] = 2'b11;
         end
         ADDR_MTVEC:  csr_rdata = mtvec_q;
         ADDR_MEPC:   csr_rdata = mepc_q;
         ADDR_MCAUSE: csr_rdata = mcause_q;
`ifdef TRAP_EXT_INTERRUPT_EN
         ADDR_MIE:    csr_rdata[11] = meie_q;
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_trap_return_unit.sv
// Directed, table-driven bench for trap_return_unit (XLEN = 32).
// Each vector drives one cycle of inputs, then after the edge checks the
// control outputs and reads one CSR.

module tb_trap_return_unit;

   logic        clk;
   logic        reset;
   logic        instr_valid;
   logic        ecall_type;
   logic        mret_type;
   logic [31:0] pc;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
`ifdef TRAP_EXT_INTERRUPT_EN
   logic        ext_irq;
`endif

   int n_total;
   int n_pass;

   trap_return_unit #(.XLEN(32), .RESET_MTVEC(32'h0000_0000)) dut (
      .clk            (clk),
      .reset          (reset),
      .instr_valid    (instr_valid),
      .ecall_type     (ecall_type),
      .mret_type      (mret_type),
      .pc             (pc),
      .csr_we         (csr_we),
      .csr_addr       (csr_addr),
      .csr_wdata      (csr_wdata),
`ifdef TRAP_EXT_INTERRUPT_EN
      .ext_irq        (ext_irq),
`endif
      .csr_rdata      (csr_rdata),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic        ec;
      logic        mr;
      logic [31:0] pc;
      logic        we;
      logic [11:0] waddr;
      logic [31:0] wdata;
      logic [11:0] raddr;
      logic        x_stall;
      logic        x_rv;
      logic [31:0] x_rpc;
      logic [31:0] x_rdata;
   } vec_t;

   localparam int unsigned NV = 24;
   vec_t vt [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic idle_inputs();
      instr_valid = 1'b0;
      ecall_type  = 1'b0;
      mret_type   = 1'b0;
      csr_we      = 1'b0;
      csr_wdata   = '0;
`ifdef TRAP_EXT_INTERRUPT_EN
      ext_irq     = 1'b0;
`endif
   endtask

   task automatic read_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
      csr_addr = a;
      #1;
      check(name, csr_rdata, exp);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      pc = '0;
      csr_addr = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One cycle: drive at negedge, sample 1ns after the posedge
   task automatic run_vec(input int i);
      @(negedge clk);
      instr_valid = vt[i].iv;
      ecall_type  = vt[i].ec;
      mret_type   = vt[i].mr;
      pc          = vt[i].pc;
      csr_we      = vt[i].we;
      csr_addr    = vt[i].waddr;
      csr_wdata   = vt[i].wdata;
      @(posedge clk);
      #1;
      idle_inputs();
      check($sformatf("v%0d stall", i), 32'(stall), 32'(vt[i].x_stall));
      check($sformatf("v%0d redirect_valid", i), 32'(redirect_valid), 32'(vt[i].x_rv));
      check($sformatf("v%0d flush", i), 32'(flush), 32'(vt[i].x_rv));
      check($sformatf("v%0d redirect_pc", i), redirect_pc, vt[i].x_rpc);
      read_csr($sformatf("v%0d csr_rdata", i), vt[i].raddr, vt[i].x_rdata);
   endtask

   function automatic vec_t mk(input logic iv, input logic ec, input logic mr, input logic [31:0] p,
                               input logic we, input logic [11:0] wa, input logic [31:0] wd,
                               input logic [11:0] ra, input logic xs, input logic xr,
                               input logic [31:0] xp, input logic [31:0] xd);
      vec_t v;
      v.iv = iv; v.ec = ec; v.mr = mr; v.pc = p;
      v.we = we; v.waddr = wa; v.wdata = wd; v.raddr = ra;
      v.x_stall = xs; v.x_rv = xr; v.x_rpc = xp; v.x_rdata = xd;
      return v;
   endfunction

   initial begin
      n_total = 0;
      n_pass  = 0;

      //          iv  ec  mr  pc        we  waddr   wdata          raddr   stall rv  rpc       rdata
      // mtvec write then ECALL at 0x80
      vt[0]  = mk(0, 0, 0, 32'h0,   1, 12'h305, 32'h0000_0103, 12'h305, 0, 0, 32'h0,   32'h100);
      vt[1]  = mk(1, 1, 0, 32'h80,  0, 12'h0,   32'h0,         12'h341, 1, 0, 32'h0,   32'h0);
      vt[2]  = mk(0, 0, 0, 32'h0,   0, 12'h0,   32'h0,         12'h341, 1, 1, 32'h100, 32'h80);
      vt[3]  = mk(0, 0, 0, 32'h0,   0, 12'h0,   32'h0,         12'h342, 0, 0, 32'h0,   32'd11);
      // mstatus.MIE=1, ECALL, MRET
      vt[4]  = mk(0, 0, 0, 32'h0,   1, 12'h300, 32'h0000_0008, 12'h300, 0, 0, 32'h0,   32'h1808);
      vt[5]  = mk(1, 1, 0, 32'h80,  0, 12'h0,   32'h0,         12'h300, 1, 0, 32'h0,   32'h1808);
      vt[6]  = mk(0, 0, 0, 32'h0,   0, 12'h0,   32'h0,         12'h300, 1, 1, 32'h100, 32'h1880);
      vt[7]  = mk(0, 0, 0, 32'h0,   0, 12'h0,   32'h0,         12'h341, 0, 0, 32'h0,   32'h80);
      vt[8]  = mk(1, 0, 1, 32'h100, 0, 12'h0,   32'h0,         12'h300, 1, 0, 32'h0,   32'h1880);
      vt[9]  = mk(0, 0, 0, 32'h0,   0, 12'h0,   32'h0,         12'h300, 1, 1, 32'h80,  32'h1888);
      vt[10] = mk(0, 0, 0, 32'h0,   0, 12'h0,   32'h0,         12'h300, 0, 0, 32'h0,   32'h1888);
      // mepc alignment, clear mcause, then ECALL+MRET together and an ignored ECALL
      vt[11] = mk(0, 0, 0, 32'h0,   1, 12'h341, 32'h0000_0003, 12'h341, 0, 0, 32'h0,   32'h0);
      vt[12] = mk(0, 0, 0, 32'h0,   1, 12'h342, 32'h0,         12'h342, 0, 0, 32'h0,   32'h0);
      vt[13] = mk(1, 1, 1, 32'h44,  0, 12'h0,   32'h0,         12'h342, 1, 0, 32'h0,   32'h0);
      vt[14] = mk(1, 1, 0, 32'h60,  0, 12'h0,   32'h0,         12'h341, 1, 1, 32'h100, 32'h44);
      vt[15] = mk(0, 0, 0, 32'h0,   0, 12'h0,   32'h0,         12'h342, 0, 0, 32'h0,   32'd11);
      vt[16] = mk(0, 0, 0, 32'h0,   0, 12'h0,   32'h0,         12'h341, 0, 0, 32'h0,   32'h44);
      // mepc write during SAVE of an ECALL is dropped
      vt[17] = mk(1, 1, 0, 32'h40,  0, 12'h0,   32'h0,         12'h341, 1, 0, 32'h0,   32'h44);
      vt[18] = mk(0, 0, 0, 32'h0,   1, 12'h341, 32'h200,       12'h341, 1, 1, 32'h100, 32'h40);
      vt[19] = mk(0, 0, 0, 32'h0,   0, 12'h0,   32'h0,         12'h341, 0, 0, 32'h0,   32'h40);
      // mcause write during REDIRECT lands; unmapped reads are 0
      vt[20] = mk(1, 1, 0, 32'h10,  0, 12'h0,   32'h0,         12'h342, 1, 0, 32'h0,   32'd11);
      vt[21] = mk(0, 0, 0, 32'h0,   0, 12'h0,   32'h0,         12'h341, 1, 1, 32'h100, 32'h10);
      vt[22] = mk(0, 0, 0, 32'h0,   1, 12'h342, 32'h5,         12'h342, 0, 0, 32'h0,   32'h5);
      vt[23] = mk(0, 0, 0, 32'h0,   0, 12'h0,   32'h0,         12'h123, 0, 0, 32'h0,   32'h0);

      do_reset();
      #1;
      check("reset stall", 32'(stall), 32'h0);
      check("reset redirect_valid", 32'(redirect_valid), 32'h0);
      check("reset redirect_pc", redirect_pc, 32'h0);
      read_csr("reset mtvec", 12'h305, 32'h0);
      read_csr("reset mstatus", 12'h300, 32'h0000_1800);
      read_csr("reset mepc", 12'h341, 32'h0);
      read_csr("reset mcause", 12'h342, 32'h0);
`ifndef TRAP_EXT_INTERRUPT_EN
      read_csr("mie unmapped", 12'h304, 32'h0);
`endif

      for (int i = 0; i < int'(NV); i++) run_vec(i);

      // csr_rdata shows the pre-edge value while a write is pending
      @(negedge clk);
      csr_we = 1'b1; csr_addr = 12'h342; csr_wdata = 32'h77;
      #1;
      check("pre-edge mcause", csr_rdata, 32'h5);
      @(posedge clk);
      #1;
      idle_inputs();
      check("post-edge mcause", csr_rdata, 32'h77);

      // Reset asserted while in SAVE abandons the trap
      do_reset();
      @(negedge clk);
      instr_valid = 1'b1; ecall_type = 1'b1; pc = 32'h30;
      @(posedge clk);
      #1;
      idle_inputs();
      check("pre-reset stall", 32'(stall), 32'h1);
      reset = 1'b1;
      #1;
      check("async reset stall", 32'(stall), 32'h0);
      check("async reset redirect_valid", 32'(redirect_valid), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("post-reset redirect_valid c%0d", k), 32'(redirect_valid), 32'h0);
         check($sformatf("post-reset stall c%0d", k), 32'(stall), 32'h0);
      end
      read_csr("post-reset mepc", 12'h341, 32'h0);
      read_csr("post-reset mcause", 12'h342, 32'h0);

`ifdef TRAP_EXT_INTERRUPT_EN
      // External interrupt trap with MIE and MEIE set
      @(negedge clk);
      csr_we = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h200;
      @(negedge clk);
      csr_addr = 12'h300; csr_wdata = 32'h8;
      @(negedge clk);
      csr_addr = 12'h304; csr_wdata = 32'h800;
      @(negedge clk);
      idle_inputs();
      ext_irq = 1'b1; pc = 32'h24;
      @(posedge clk);
      #1;
      ext_irq = 1'b0;
      check("irq stall", 32'(stall), 32'h1);
      @(posedge clk);
      #1;
      check("irq redirect_valid", 32'(redirect_valid), 32'h1);
      check("irq redirect_pc", redirect_pc, 32'h200);
      read_csr("irq mcause", 12'h342, 32'h8000_000B);
      read_csr("irq mepc", 12'h341, 32'h24);
      read_csr("irq mie", 12'h304, 32'h800);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
